// File: rtl/bounce_counter.sv
// Programmable sweep generator: walks x between lo and hi by step in triangle,
// sawtooth-up, sawtooth-down or hold mode, with a one-cycle turn/wrap pulse.
module bounce_counter #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         dwell,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] step,
  output logic [W-1:0] x,
  output logic         dir,
  output logic         turn
);

  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW_UP = 2'd1,
    MODE_SAW_DN = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  mode_e          mode_s;
  logic [W-1:0]   x_q, x_d;
  logic           dir_q, dir_d;
  logic           turn_q, turn_d;

  logic [W:0]     x_up_sum, lo_up_sum;
  logic [W:0]     x_dn_diff, hi_dn_diff;
  logic [W-1:0]   x_up, lo_up, x_dn, hi_dn;

  assign mode_s = mode_e'(mode);

  // Sums/differences carry one extra bit so overflow and borrow are visible
  // and the result can be clamped to the range instead of wrapping.
  assign x_up_sum   = {1'b0, x_q} + {1'b0, step};
  assign lo_up_sum  = {1'b0, lo}  + {1'b0, step};
  assign x_dn_diff  = {1'b0, x_q} - {1'b0, step};
  assign hi_dn_diff = {1'b0, hi}  - {1'b0, step};

  assign x_up  = (x_up_sum  > {1'b0, hi}) ? hi : x_up_sum[W-1:0];
  assign lo_up = (lo_up_sum > {1'b0, hi}) ? hi : lo_up_sum[W-1:0];
  assign x_dn  = (x_dn_diff[W]  || (x_dn_diff[W-1:0]  < lo)) ? lo : x_dn_diff[W-1:0];
  assign hi_dn = (hi_dn_diff[W] || (hi_dn_diff[W-1:0] < lo)) ? lo : hi_dn_diff[W-1:0];

  always_comb begin
    x_d    = x_q;
    dir_d  = dir_q;
    turn_d = 1'b0;
    if (!en) begin
      x_d = x_q;
    end else if (lo >= hi) begin
      x_d   = lo;
      dir_d = 1'b1;
    end else if (x_q > hi) begin
      x_d = hi;
    end else if (x_q < lo) begin
      x_d = lo;
    end else begin
      case (mode_s)
        MODE_TRI: begin
          if (dir_q) begin
            if (x_q == hi) begin
              x_d    = dwell ? x_q : hi_dn;
              dir_d  = 1'b0;
              turn_d = 1'b1;
            end else begin
              x_d = x_up;
            end
          end else begin
            if (x_q == lo) begin
              x_d    = dwell ? x_q : lo_up;
              dir_d  = 1'b1;
              turn_d = 1'b1;
            end else begin
              x_d = x_dn;
            end
          end
        end
        MODE_SAW_UP: begin
          dir_d = 1'b1;
          if (x_q == hi) begin
            x_d    = lo;
            turn_d = 1'b1;
          end else begin
            x_d = x_up;
          end
        end
        MODE_SAW_DN: begin
          dir_d = 1'b0;
          if (x_q == lo) begin
            x_d    = hi;
            turn_d = 1'b1;
          end else begin
            x_d = x_dn;
          end
        end
        default: begin
          x_d = x_q;
        end
      endcase
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      dir_q  <= 1'b1;
      turn_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      dir_q  <= dir_d;
      turn_q <= turn_d;
    end
  end

  assign x    = x_q;
  assign dir  = dir_q;
  assign turn = turn_q;

endmodule

// File: doc/bounce_counter.md
Name: bounce_counter

Overview:
Parametrised successor to the team's 4-bit up/down bounce counter. Counts between programmable bounds lo and hi in a configurable step, in triangle, sawtooth-up, sawtooth-down or hold mode. The turnaround dwell is selectable. The block drives a direction flag and a one-cycle turn/wrap pulse. It is used as a sweep/scan generator feeding address, PWM-compare and test-pattern logic.

Parameters:
W, 8, counter/bound/step width in bits (W >= 2)

Ports:
ck    input   1   clock; all state changes on posedge
rst   input   1   asynchronous reset, active-low (0 = reset)
en    input   1   count enable; 0 freezes x and dir
mode  input   2   0 triangle, 1 saw up, 2 saw down, 3 hold
dwell input   1   triangle only: 1 = hold endpoint one extra cycle at each turnaround
lo    input   W   lower bound (unsigned, inclusive)
hi    input   W   upper bound (unsigned, inclusive)
step  input   W   increment magnitude (unsigned)
x     output  W   registered count value
dir   output  1   registered direction, 1 = up, 0 = down
turn  output  1   registered pulse, high for one cycle after each turnaround or wrap

Behaviour:
- Reset (rst=0, async, no clock needed): x=0, dir=1, turn=0. These values are held until the first posedge after rst rises.
- All outputs are registered. There is no combinational path from inputs to outputs.
- en=0: x and dir hold; turn<=0.
- Arithmetic: x+step and x-step are computed in W+1 bits, so there is no modular overflow. Results are clamped to [lo,hi].
- Evaluation priority on each enabled edge (first match wins):
  1. lo >= hi: x<=lo, dir<=1, turn<=0 (degenerate range).
  2. x > hi: x<=hi, turn<=0; dir unchanged.
  3. x < lo: x<=lo, turn<=0; dir unchanged.
  4. Mode action, as below.
- mode 0, triangle, dir=1:
  - x==hi, dwell=1: x holds; dir<=0; turn<=1.
  - x==hi, dwell=0: x<=max(hi-step, lo); dir<=0; turn<=1.
  - otherwise: x<=min(x+step, hi); turn<=0.
- mode 0, triangle, dir=0: mirror of dir=1.
  - x==lo, dwell=1: x holds; dir<=1; turn<=1.
  - x==lo, dwell=0: x<=min(lo+step, hi); dir<=1; turn<=1.
  - otherwise: x<=max(x-step, lo); turn<=0.
- mode 1, saw up: dir<=1.
  - x==hi: x<=lo; turn<=1.
  - otherwise: x<=min(x+step, hi); turn<=0.
- mode 2, saw down: dir<=0.
  - x==lo: x<=hi; turn<=1.
  - otherwise: x<=max(x-step, lo); turn<=0.
- mode 3, hold: x and dir hold; turn<=0.
- step=0: x stays at its value; endpoint actions still fire if x sits on the active endpoint.
- Mode, bound and step changes take effect at the next enabled edge. There is no pipeline and no reset of x on a mode change.
- Triangle period with step=1, x starting at lo, dir=1:
  - dwell=1: 2*(hi-lo+1) cycles.
  - dwell=0: 2*(hi-lo) cycles.
- Setting W=4, lo=0, hi=15, step=1, mode=0, dwell=1 reproduces the legacy bounce sequence 0..15,15,14..0,0,...
- Reset asserted mid-count clears x, dir and turn immediately. Counting restarts from the reset state once rst is deasserted.

Test Plan:
1. Reset: hold rst=0 mid-count, toggle ck -> x=0, dir=1, turn=0 asynchronously. Release with lo=0, hi=3, step=1, mode=0, dwell=1, en=1 -> x = 1,2,3,3,2,1,0,0,1. turn high in the cycle with the second 3 and the second 0.
2. Triangle, no dwell: lo=2, hi=9, step=3, dwell=0, start x=2 -> x = 5,8,9,6(turn,dir=0),3,2,5(turn,dir=1).
3. Saw modes: mode=1, lo=4, hi=7, step=2 -> x = 6,7,4(turn),6. Then switch to mode=2 -> dir=0, x = 4,7(turn),5,4.
4. Enable/hold: en=0 for 5 cycles mid-ramp -> x and dir frozen, turn=0. Same check with mode=3 and en=1.
5. Bounds: with x=0 and lo=10, hi=20, first edge -> x=10, no turn. Then drop hi to 12 while x=15 -> next x=12. Set lo=hi=12 -> x=12, dir=1, turn=0 every cycle.
6. Width edge: W=8, lo=0, hi=255, step=200, mode=0, dwell=0 from x=200 -> x=255 (no wrap to 144), then 55 with turn=1, then 0, then 200 with turn=1.
